// File: rtl/cn_min_seq_if.sv
// cn_min_seq_if -- streaming bus of the sequential check-node min/submin unit.
//
// Signals
//   in_valid    : producer has a magnitude on in_data
//   in_ready    : unit accepts in_data this cycle
//   in_data     : unsigned magnitude, WIDTH bits
//   out_valid   : row result is available
//   out_ready   : consumer accepts the row result this cycle
//   out_min     : row minimum
//   out_submin  : row second minimum
//   out_min_idx : row position of out_min
//   out_row_cnt : completed row handshakes, mod 256
//
// Modports
//   master : producer/consumer side (testbench or upstream/downstream logic)
//   slave  : the cn_min_seq unit
interface cn_min_seq_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_min;
  logic [WIDTH-1:0] out_submin;
  logic [IDX_W-1:0] out_min_idx;
  logic [7:0]       out_row_cnt;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_min, out_submin, out_min_idx, out_row_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_min, out_submin, out_min_idx, out_row_cnt
  );
endinterface

// File: rtl/cn_min_seq.sv
// cn_min_seq -- sequential check-node min/submin unit.
//
// One magnitude per accepted beat is folded into a running (min, submin,
// min_idx) triple through a single 3-input comparator. After ROW_LEN beats
// the result is held until the consumer takes it; a new row may start in the
// same cycle the previous result is taken, so rows stream without bubbles.
//
// Ports
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (highest priority)
//   flush : synchronous abort of the partial row / pending result
//   bus   : cn_min_seq_if.slave (input beat stream and row result stream)
module cn_min_seq #(
  parameter int WIDTH   = 8,
  parameter int ROW_LEN = 24,
  parameter int IDX_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  cn_min_seq_if.slave bus
);

  // One extra bit so the beat count can reach ROW_LEN even when ROW_LEN == 2^IDX_W.
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ROW_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic             take_idx;
    logic [WIDTH-1:0] min;
    logic [WIDTH-1:0] sub;
  } cmp_t;

  // 3-input min/submin comparator: in_1 = running min, in_2 = running submin,
  // in_3 = new magnitude. Only a strictly smaller value moves the min index;
  // a tie with the min lands in submin.
  function automatic cmp_t cmp3(input logic [WIDTH-1:0] in_1,
                                input logic [WIDTH-1:0] in_2,
                                input logic [WIDTH-1:0] in_3);
    cmp_t r;
    if (in_3 < in_1) begin
      r.take_idx = 1'b1;
      r.min      = in_3;
      r.sub      = in_1;
    end else if (in_3 < in_2) begin
      r.take_idx = 1'b0;
      r.min      = in_1;
      r.sub      = in_3;
    end else begin
      r.take_idx = 1'b0;
      r.min      = in_1;
      r.sub      = in_2;
    end
    return r;
  endfunction

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] min_r;
  logic [WIDTH-1:0] submin_r;
  logic [IDX_W-1:0] idx_r;
  logic [CNT_W-1:0] beat_cnt_r;
  logic [7:0]       row_cnt_r;
  logic             in_ready_s;
  logic             out_valid_s;
  logic             in_fire_s;
  logic             out_fire_s;
  logic             last_beat_s;
  cmp_t             cmp_s;

  // Handshake qualifiers; flush blocks the result handshake and in_ready_s
  // already carries the rst/flush gating for the input side.
  assign in_fire_s   = bus.in_valid && in_ready_s;
  assign out_fire_s  = out_valid_s && bus.out_ready && !flush;
  assign last_beat_s = (beat_cnt_r == LAST_BEAT);

  // Comparator instance fed by the running state and the incoming beat.
  always_comb begin
    cmp_s = cmp3(min_r, submin_r, bus.in_data);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; flush overrides every handshake.
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_fire_s) begin
            state_next_s = ST_ACCUM;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_ACCUM: begin
          if (in_fire_s && last_beat_s) begin
            state_next_s = ST_HOLD;
          end else begin
            state_next_s = ST_ACCUM;
          end
        end
        ST_HOLD: begin
          // An input beat in HOLD implies out_ready, so it always coincides
          // with the result handshake and opens the next row.
          if (out_fire_s && in_fire_s) begin
            state_next_s = ST_ACCUM;
          end else if (out_fire_s) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_HOLD;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode: in_ready follows out_ready in HOLD so a new row can start
  // in the same cycle the result leaves.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    if (rst) begin
      in_ready_s  = 1'b0;
      out_valid_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          in_ready_s  = !flush;
          out_valid_s = 1'b0;
        end
        ST_ACCUM: begin
          in_ready_s  = !flush;
          out_valid_s = 1'b0;
        end
        ST_HOLD: begin
          in_ready_s  = bus.out_ready && !flush;
          out_valid_s = 1'b1;
        end
        default: begin
          in_ready_s  = 1'b0;
          out_valid_s = 1'b0;
        end
      endcase
    end
  end

  // Running min/submin/index and beat position; only an accepted beat loads
  // them, so an undriven in_data never reaches the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      min_r      <= {WIDTH{1'b0}};
      submin_r   <= {WIDTH{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      beat_cnt_r <= {CNT_W{1'b0}};
    end else if (flush) begin
      beat_cnt_r <= {CNT_W{1'b0}};
    end else if (in_fire_s) begin
      if (state_r == ST_ACCUM) begin
        min_r      <= cmp_s.min;
        submin_r   <= cmp_s.sub;
        if (cmp_s.take_idx) begin
          idx_r <= beat_cnt_r[IDX_W-1:0];
        end
        beat_cnt_r <= beat_cnt_r + CNT_W'(1);
      end else begin
        // First beat of a row, from IDLE or straight out of HOLD.
        min_r      <= bus.in_data;
        submin_r   <= {WIDTH{1'b1}};
        idx_r      <= {IDX_W{1'b0}};
        beat_cnt_r <= CNT_W'(1);
      end
    end
  end

  // Completed-row counter, wraps naturally at 256.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt_r <= 8'd0;
    end else if (out_fire_s) begin
      row_cnt_r <= row_cnt_r + 8'd1;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_s;
  assign bus.out_min     = min_r;
  assign bus.out_submin  = submin_r;
  assign bus.out_min_idx = idx_r;
  assign bus.out_row_cnt = row_cnt_r;

endmodule

// File: tb/tb_cn_min_seq.sv
// tb_cn_min_seq -- self-checking bench for cn_min_seq.
// A row-level model (queue of accepted beats, scanned when full) predicts
// every output on every cycle; directed rows pin the model with literal
// expectations, then randomized traffic with stalls and flushes follows.
module tb_cn_min_seq;
  localparam int WIDTH   = 8;
  localparam int ROW_LEN = 24;
  localparam int IDX_W   = 5;

  logic clk;
  logic rst;
  logic flush;
  int   n_vec;
  int   n_err;
  int   cyc;

  cn_min_seq_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

  cn_min_seq #(.WIDTH(WIDTH), .ROW_LEN(ROW_LEN), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int row_q[$];
  bit pend;
  int p_min, p_sub, p_idx;
  int m_cnt;

  // Check at the falling edge, then advance the model by what the next
  // rising edge will do with the inputs that are now stable.
  always @(negedge clk) begin
    int  exp_ready;
    bit  in_fire, out_fire;
    if (rst) exp_ready = 0;
    else if (flush) exp_ready = 0;
    else if (pend) exp_ready = int'(bus.out_ready);
    else exp_ready = 1;
    chk("in_ready", int'(bus.in_ready), exp_ready);
    chk("out_valid", int'(bus.out_valid), int'(pend && !rst));
    chk("out_row_cnt", int'(bus.out_row_cnt), m_cnt);
    if (pend && !rst) begin
      chk("out_min", int'(bus.out_min), p_min);
      chk("out_submin", int'(bus.out_submin), p_sub);
      chk("out_min_idx", int'(bus.out_min_idx), p_idx);
    end
    if (rst) begin
      row_q.delete();
      pend  = 0;
      m_cnt = 0;
    end else if (flush) begin
      row_q.delete();
      pend = 0;
    end else begin
      out_fire = pend && bus.out_ready;
      in_fire  = bus.in_valid && (exp_ready != 0);
      if (out_fire) begin
        pend  = 0;
        m_cnt = (m_cnt + 1) % 256;
      end
      if (in_fire) begin
        row_q.push_back(int'(bus.in_data));
        if (row_q.size() == ROW_LEN) begin
          // First occurrence of the smallest value, then smallest of the rest.
          p_min = row_q[0];
          p_idx = 0;
          foreach (row_q[i]) if (row_q[i] < p_min) begin p_min = row_q[i]; p_idx = i; end
          p_sub = 1 << WIDTH;
          foreach (row_q[i]) if (i != p_idx && row_q[i] < p_sub) p_sub = row_q[i];
          pend = 1;
          row_q.delete();
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_beat(input int d);
    int guard;
    bit done;
    guard = 0;
    done  = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d[WIDTH-1:0];
    while (!done) begin
      @(negedge clk);
      done = bus.in_ready;
      @(posedge clk);
      #1;
      guard++;
      if (!done && guard > 50) begin
        chk("beat_accept_timeout", 0, 1);
        done = 1;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 'x;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    pend  = 0;
    m_cnt = 0;
    rst   = 1'b1;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_row_cnt", int'(bus.out_row_cnt), 0);
    chk("rst_out_min", int'(bus.out_min), 0);
    chk("rst_out_idx", int'(bus.out_min_idx), 0);
    rst = 1'b0;
    idle_cycle();

    // rst in the middle of a row, then a clean ascending row.
    for (int i = 0; i < 10; i++) push_beat(i);
    do_reset();
    for (int i = 0; i < ROW_LEN; i++) push_beat(10 + i);
    chk("rst_row_min", int'(bus.out_min), 10);
    chk("rst_row_sub", int'(bus.out_submin), 11);
    chk("rst_row_idx", int'(bus.out_min_idx), 0);
    idle_cycle();
    chk("rst_row_cnt1", int'(bus.out_row_cnt), 1);

    // Descending row: valid exactly one cycle after the last beat.
    for (int i = 0; i < ROW_LEN; i++) push_beat(200 - i);
    chk("desc_valid", int'(bus.out_valid), 1);
    chk("desc_min", int'(bus.out_min), 177);
    chk("desc_sub", int'(bus.out_submin), 178);
    chk("desc_idx", int'(bus.out_min_idx), 23);
    idle_cycle();

    // Ascending row.
    for (int i = 0; i < ROW_LEN; i++) push_beat(10 + i);
    chk("asc_min", int'(bus.out_min), 10);
    chk("asc_sub", int'(bus.out_submin), 11);
    chk("asc_idx", int'(bus.out_min_idx), 0);
    idle_cycle();

    // Tie row: the earlier of two equal minima keeps the index.
    for (int i = 0; i < ROW_LEN; i++) push_beat((i == 5 || i == 9) ? 7 : 50);
    chk("tie_min", int'(bus.out_min), 7);
    chk("tie_sub", int'(bus.out_submin), 7);
    chk("tie_idx", int'(bus.out_min_idx), 5);
    idle_cycle();

    // Two back-to-back rows with zero bubbles.
    do_reset();
    c0 = cyc;
    for (int i = 0; i < 2 * ROW_LEN; i++) begin
      push_beat($urandom_range(0, 255));
      if (i == ROW_LEN) chk("b2b_cnt1", int'(bus.out_row_cnt), 1);
    end
    chk("b2b_cycles", cyc - c0, 2 * ROW_LEN);
    idle_cycle();
    chk("b2b_cnt2", int'(bus.out_row_cnt), 2);

    // Result stalled in HOLD for five cycles with input offered.
    bus.out_ready = 1'b0;
    for (int i = 0; i < ROW_LEN; i++) push_beat(200 - i);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", int'(bus.in_ready), 0);
      chk("stall_min", int'(bus.out_min), 177);
      chk("stall_idx", int'(bus.out_min_idx), 23);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    idle_cycle();

    // flush at beat 10 (beat offered in the same cycle), then ascending row.
    do_reset();
    for (int i = 0; i < 10; i++) push_beat(i);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd0;
    flush        = 1'b1;
    idle_cycle();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < ROW_LEN; i++) push_beat(10 + i);
    chk("flush_min", int'(bus.out_min), 10);
    chk("flush_sub", int'(bus.out_submin), 11);
    chk("flush_idx", int'(bus.out_min_idx), 0);
    idle_cycle();
    chk("flush_cnt", int'(bus.out_row_cnt), 1);

    // Randomized traffic with backpressure and occasional flush.
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_data   = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15))
                                                  : 8'($urandom_range(0, 255));
      bus.out_ready = ($urandom_range(0, 9) < 7);
      flush         = ($urandom_range(0, 63) == 0);
      idle_cycle();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    flush         = 1'b0;
    repeat (3) idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
